// File: rtl/prog_loader_if.sv
// Host/loader bus bundle: program load control, byte stream, instruction-memory
// write port, and the start handoff to fetch. The loader is the slave; the host
// side (driver of load_i and the byte stream) is the master.
interface prog_loader_if;
  logic        load_i;
  logic [15:0] base_addr_i;
  logic        byte_valid_i;
  logic [7:0]  byte_i;
  logic        byte_ready_o;
  logic        imem_we_o;
  logic [15:0] imem_addr_o;
  logic [8:0]  imem_data_o;
  logic        start_o;
  logic [15:0] start_address_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  modport slave (
    input  load_i, base_addr_i, byte_valid_i, byte_i,
    output byte_ready_o, imem_we_o, imem_addr_o, imem_data_o,
           start_o, start_address_o, busy_o, done_o, err_o
  );

  modport master (
    output load_i, base_addr_i, byte_valid_i, byte_i,
    input  byte_ready_o, imem_we_o, imem_addr_o, imem_data_o,
           start_o, start_address_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/prog_loader.sv
// Program loader: parses a little-endian byte stream (count, then 9-bit
// instruction words split over two bytes) and writes the words to instruction
// memory starting at a latched base address, then pulses start to fetch.
// A non-zero high byte above bit 0 aborts the load into ERR.
module prog_loader (
  input  logic          clk,
  input  logic          rst_n,
  prog_loader_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    INS_LO,
    INS_HI,
    WRITE,
    START,
    DONE,
    ERR
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] idx_reg, idx_next;
  logic [15:0] len_reg, len_next;
  logic [15:0] base_reg, base_next;
  logic [7:0]  lo_reg, lo_next;
  logic        hi_bit_reg, hi_bit_next;

  logic        ready;
  logic        xfer;

  // Bytes are only accepted in the four parsing states.
  assign ready = (state_reg == LEN_LO) || (state_reg == LEN_HI) ||
                 (state_reg == INS_LO) || (state_reg == INS_HI);
  assign xfer  = ready && bus.byte_valid_i;

  // State and datapath registers; reset wins over everything, including a load in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      idx_reg    <= 16'd0;
      len_reg    <= 16'd0;
      base_reg   <= 16'd0;
      lo_reg     <= 8'd0;
      hi_bit_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      len_reg    <= len_next;
      base_reg   <= base_next;
      lo_reg     <= lo_next;
      hi_bit_reg <= hi_bit_next;
    end
  end

  // Next-state logic: stalls in place whenever no byte transfers.
  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    len_next    = len_reg;
    base_next   = base_reg;
    lo_next     = lo_reg;
    hi_bit_next = hi_bit_reg;
    case (state_reg)
      IDLE, DONE, ERR: begin
        if (bus.load_i) begin
          state_next = LEN_LO;
          idx_next   = 16'd0;
          base_next  = bus.base_addr_i;
        end
      end
      LEN_LO: begin
        if (xfer) begin
          len_next[7:0] = bus.byte_i;
          state_next    = LEN_HI;
        end
      end
      LEN_HI: begin
        if (xfer) begin
          len_next[15:8] = bus.byte_i;
          // An empty program goes straight to the start handoff.
          if ({bus.byte_i, len_reg[7:0]} == 16'd0) begin
            state_next = START;
          end else begin
            state_next = INS_LO;
          end
        end
      end
      INS_LO: begin
        if (xfer) begin
          lo_next    = bus.byte_i;
          state_next = INS_HI;
        end
      end
      INS_HI: begin
        if (xfer) begin
          if (bus.byte_i[7:1] != 7'd0) begin
            state_next = ERR;
          end else begin
            hi_bit_next = bus.byte_i[0];
            state_next  = WRITE;
          end
        end
      end
      WRITE: begin
        idx_next = idx_reg + 16'd1;
        // Compare against N-1 so that N == 0xFFFF never needs a 17-bit index.
        if (idx_reg == len_reg - 16'd1) begin
          state_next = START;
        end else begin
          state_next = INS_LO;
        end
      end
      START: begin
        state_next = DONE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs decode from state; the address adds in 16 bits so it wraps naturally.
  assign bus.byte_ready_o    = ready;
  assign bus.imem_we_o       = (state_reg == WRITE);
  assign bus.imem_addr_o     = base_reg + idx_reg;
  assign bus.imem_data_o     = {hi_bit_reg, lo_reg};
  assign bus.start_o         = (state_reg == START);
  assign bus.start_address_o = base_reg;
  assign bus.busy_o          = (state_reg != IDLE) && (state_reg != DONE) &&
                               (state_reg != ERR);
  assign bus.done_o          = (state_reg == DONE);
  assign bus.err_o           = (state_reg == ERR);

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: expected memory writes are queued as each
// stream is built, and compared against the writes captured from the DUT.
module tb_prog_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prog_loader_if bus ();

  prog_loader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [15:0] addr;
    logic [8:0]  data;
  } wr_t;

  int pass_cnt = 0;
  int total_cnt = 0;

  wr_t         exp_wr[$];
  wr_t         obs_wr[$];
  logic [15:0] obs_start[$];

  // Capture every write strobe and start pulse away from the active edge.
  always @(negedge clk) begin
    if (bus.imem_we_o === 1'b1) obs_wr.push_back({bus.imem_addr_o, bus.imem_data_o});
    if (bus.start_o === 1'b1) obs_start.push_back(bus.start_address_o);
  end

  // Stimulus: one-cycle load pulse; entered and left at posedge+1.
  task automatic do_load(input logic [15:0] base);
    bus.base_addr_i = base;
    bus.load_i = 1'b1;
    @(posedge clk); #1;
    bus.load_i = 1'b0;
  endtask

  // Stimulus: present bytes until each one has transferred; optional random stalls.
  task automatic send_bytes(input logic [7:0] b[$], input bit rnd, output bit ok);
    int i;
    int guard;
    bit go;
    i = 0;
    guard = 0;
    ok = 1'b1;
    while (i < b.size()) begin
      bus.byte_i = b[i];
      bus.byte_valid_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      go = bus.byte_valid_i && (bus.byte_ready_o === 1'b1);
      @(posedge clk); #1;
      if (go) i++;
      guard++;
      if (guard > 4000) begin
        ok = 1'b0;
        break;
      end
    end
    bus.byte_valid_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.load_i = 1'b1;
    bus.base_addr_i = 16'h1234;
    bus.byte_valid_i = 1'b1;
    bus.byte_i = 8'h55;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({bus.byte_ready_o, bus.imem_we_o, bus.imem_addr_o, bus.imem_data_o, bus.start_o,
         bus.start_address_o, bus.busy_o, bus.done_o, bus.err_o} !== '0)
      $display("FAIL reset_outputs: got busy=%b ready=%b addr=%h want all zero",
               bus.busy_o, bus.byte_ready_o, bus.imem_addr_o);
    else pass_cnt++;
    bus.load_i = 1'b0;
    bus.byte_valid_i = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (bus.busy_o !== 1'b0 || bus.byte_ready_o !== 1'b0)
      $display("FAIL reset_idle_hold: got busy=%b ready=%b want 0/0", bus.busy_o, bus.byte_ready_o);
    else pass_cnt++;
    $display("test_reset: done");
  endtask

  task automatic test_basic;
    logic [7:0] q[$];
    bit ok;
    wr_t e, o;
    obs_wr.delete(); obs_start.delete();
    exp_wr.push_back({16'h0010, 9'h1A5});
    exp_wr.push_back({16'h0011, 9'h03C});
    do_load(16'h0010);
    total_cnt++;
    if (bus.busy_o !== 1'b1 || bus.byte_ready_o !== 1'b1)
      $display("FAIL basic_busy: got busy=%b ready=%b want 1/1", bus.busy_o, bus.byte_ready_o);
    else pass_cnt++;
    q = '{8'h02, 8'h00, 8'hA5, 8'h01, 8'h3C, 8'h00};
    send_bytes(q, 1'b0, ok);
    total_cnt++;
    if (!ok) $display("FAIL basic_timeout: got stalled stream want all bytes accepted");
    else pass_cnt++;
    // One cycle after the last INS_HI transfer the write strobe is up.
    total_cnt++;
    if (bus.imem_we_o !== 1'b1 || bus.imem_addr_o !== 16'h0011)
      $display("FAIL basic_wr_latency: got we=%b addr=%h want 1/0011", bus.imem_we_o, bus.imem_addr_o);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (bus.start_o !== 1'b1 || bus.start_address_o !== 16'h0010)
      $display("FAIL basic_start: got start=%b addr=%h want 1/0010", bus.start_o, bus.start_address_o);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (bus.done_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.start_o !== 1'b0)
      $display("FAIL basic_done: got done=%b busy=%b start=%b want 1/0/0", bus.done_o, bus.busy_o, bus.start_o);
    else pass_cnt++;
    total_cnt++;
    if (obs_wr.size() !== exp_wr.size())
      $display("FAIL basic_wr_count: got %0d want %0d", obs_wr.size(), exp_wr.size());
    else pass_cnt++;
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      e = exp_wr.pop_front(); o = obs_wr.pop_front();
      total_cnt++;
      if (o !== e) $display("FAIL basic_wr: got %h/%h want %h/%h", o.addr, o.data, e.addr, e.data);
      else pass_cnt++;
    end
    total_cnt++;
    if (obs_start.size() !== 1)
      $display("FAIL basic_start_count: got %0d want 1", obs_start.size());
    else pass_cnt++;
    exp_wr.delete();
    $display("test_basic: done");
  endtask

  task automatic test_empty;
    logic [7:0] q[$];
    bit ok;
    obs_wr.delete(); obs_start.delete();
    do_load(16'h0040);
    q = '{8'h00, 8'h00};
    send_bytes(q, 1'b0, ok);
    total_cnt++;
    if (bus.start_o !== 1'b1 || bus.start_address_o !== 16'h0040 || !ok)
      $display("FAIL empty_start: got start=%b addr=%h ok=%b want 1/0040/1", bus.start_o, bus.start_address_o, ok);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (bus.done_o !== 1'b1 || bus.start_o !== 1'b0)
      $display("FAIL empty_done: got done=%b start=%b want 1/0", bus.done_o, bus.start_o);
    else pass_cnt++;
    total_cnt++;
    if (obs_wr.size() !== 0)
      $display("FAIL empty_no_write: got %0d writes want 0", obs_wr.size());
    else pass_cnt++;
    $display("test_empty: done");
  endtask

  task automatic test_wrap;
    logic [7:0] q[$];
    bit ok;
    int n;
    wr_t e, o;
    obs_wr.delete(); obs_start.delete();
    exp_wr.push_back({16'hFFFF, 9'h1FF});
    exp_wr.push_back({16'h0000, 9'h000});
    do_load(16'hFFFF);
    q = '{8'h02, 8'h00, 8'hFF, 8'h01, 8'h00, 8'h00};
    send_bytes(q, 1'b0, ok);
    n = 0;
    while (bus.done_o !== 1'b1 && bus.err_o !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    total_cnt++;
    if (bus.done_o !== 1'b1 || !ok)
      $display("FAIL wrap_done: got done=%b err=%b ok=%b want 1/0/1", bus.done_o, bus.err_o, ok);
    else pass_cnt++;
    total_cnt++;
    if (obs_wr.size() !== exp_wr.size())
      $display("FAIL wrap_wr_count: got %0d want %0d", obs_wr.size(), exp_wr.size());
    else pass_cnt++;
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      e = exp_wr.pop_front(); o = obs_wr.pop_front();
      total_cnt++;
      if (o !== e) $display("FAIL wrap_wr: got %h/%h want %h/%h", o.addr, o.data, e.addr, e.data);
      else pass_cnt++;
    end
    exp_wr.delete();
    $display("test_wrap: done");
  endtask

  task automatic test_error;
    logic [7:0] q[$];
    bit ok;
    int n;
    wr_t e, o;
    obs_wr.delete(); obs_start.delete();
    exp_wr.push_back({16'h0100, 9'h011});
    do_load(16'h0100);
    q = '{8'h02, 8'h00, 8'h11, 8'h00, 8'h22, 8'h02};
    send_bytes(q, 1'b0, ok);
    total_cnt++;
    if (bus.err_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || !ok)
      $display("FAIL error_state: got err=%b busy=%b done=%b want 1/0/0", bus.err_o, bus.busy_o, bus.done_o);
    else pass_cnt++;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (obs_start.size() !== 0)
      $display("FAIL error_no_start: got %0d start pulses want 0", obs_start.size());
    else pass_cnt++;
    total_cnt++;
    if (obs_wr.size() !== exp_wr.size())
      $display("FAIL error_wr_count: got %0d want %0d", obs_wr.size(), exp_wr.size());
    else pass_cnt++;
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      e = exp_wr.pop_front(); o = obs_wr.pop_front();
      total_cnt++;
      if (o !== e) $display("FAIL error_wr: got %h/%h want %h/%h", o.addr, o.data, e.addr, e.data);
      else pass_cnt++;
    end
    exp_wr.delete();
    do_load(16'h0300);
    total_cnt++;
    if (bus.err_o !== 1'b0 || bus.busy_o !== 1'b1)
      $display("FAIL error_clear: got err=%b busy=%b want 0/1", bus.err_o, bus.busy_o);
    else pass_cnt++;
    q = '{8'h00, 8'h00};
    send_bytes(q, 1'b0, ok);
    n = 0;
    while (bus.done_o !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    obs_wr.delete(); obs_start.delete();
    $display("test_error: done");
  endtask

  task automatic test_stall;
    logic [7:0] q[$];
    wr_t model[$];
    bit ok;
    int n;
    wr_t e, o;
    logic [7:0] lo;
    logic hi;
    q = '{8'h06, 8'h00};
    for (int k = 0; k < 6; k++) begin
      lo = 8'($urandom_range(0, 255));
      hi = 1'($urandom_range(0, 1));
      q.push_back(lo);
      q.push_back({7'd0, hi});
      model.push_back({16'h0200 + 16'(k), {hi, lo}});
    end
    for (int pass = 0; pass < 2; pass++) begin
      obs_wr.delete(); obs_start.delete();
      exp_wr = model;
      do_load(16'h0200);
      send_bytes(q, pass == 1, ok);
      n = 0;
      while (bus.done_o !== 1'b1 && bus.err_o !== 1'b1 && n < 20) begin
        @(posedge clk); #1; n++;
      end
      total_cnt++;
      if (bus.done_o !== 1'b1 || !ok)
        $display("FAIL stall_done[%0d]: got done=%b ok=%b want 1/1", pass, bus.done_o, ok);
      else pass_cnt++;
      total_cnt++;
      if (obs_wr.size() !== exp_wr.size())
        $display("FAIL stall_wr_count[%0d]: got %0d want %0d", pass, obs_wr.size(), exp_wr.size());
      else pass_cnt++;
      while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
        e = exp_wr.pop_front(); o = obs_wr.pop_front();
        total_cnt++;
        if (o !== e) $display("FAIL stall_wr[%0d]: got %h/%h want %h/%h", pass, o.addr, o.data, e.addr, e.data);
        else pass_cnt++;
      end
      total_cnt++;
      if (obs_start.size() !== 1 || obs_start[0] !== 16'h0200)
        $display("FAIL stall_start[%0d]: got %0d pulses want 1 at 0200", pass, obs_start.size());
      else pass_cnt++;
      exp_wr.delete();
    end
    $display("test_stall: done");
  endtask

  task automatic test_back_to_back;
    logic [7:0] q[$];
    bit ok;
    int n;
    wr_t e, o;
    obs_wr.delete(); obs_start.delete();
    exp_wr.push_back({16'h0600, 9'h055});
    do_load(16'h0600);
    // A load request mid-stream must not restart or re-base the load.
    do_load(16'h0700);
    q = '{8'h01, 8'h00, 8'h55, 8'h00};
    send_bytes(q, 1'b0, ok);
    n = 0;
    while (bus.done_o !== 1'b1 && bus.err_o !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    total_cnt++;
    if (bus.done_o !== 1'b1 || bus.start_address_o !== 16'h0600 || !ok)
      $display("FAIL b2b_done: got done=%b addr=%h want 1/0600", bus.done_o, bus.start_address_o);
    else pass_cnt++;
    total_cnt++;
    if (obs_wr.size() !== exp_wr.size())
      $display("FAIL b2b_wr_count: got %0d want %0d", obs_wr.size(), exp_wr.size());
    else pass_cnt++;
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      e = exp_wr.pop_front(); o = obs_wr.pop_front();
      total_cnt++;
      if (o !== e) $display("FAIL b2b_wr: got %h/%h want %h/%h", o.addr, o.data, e.addr, e.data);
      else pass_cnt++;
    end
    exp_wr.delete();
    $display("test_back_to_back: done");
  endtask

  task automatic test_reset_mid;
    logic [7:0] q[$];
    bit ok;
    obs_wr.delete(); obs_start.delete();
    do_load(16'h0500);
    q = '{8'h02, 8'h00};
    send_bytes(q, 1'b0, ok);
    // Now sitting in INS_LO with a byte offered while reset asserts.
    bus.byte_i = 8'h77;
    bus.byte_valid_i = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if ({bus.byte_ready_o, bus.imem_we_o, bus.imem_addr_o, bus.imem_data_o, bus.start_o,
         bus.start_address_o, bus.busy_o, bus.done_o, bus.err_o} !== '0 || !ok)
      $display("FAIL midreset_outputs: got busy=%b ready=%b saddr=%h want all zero",
               bus.busy_o, bus.byte_ready_o, bus.start_address_o);
    else pass_cnt++;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (bus.byte_ready_o !== 1'b0 || bus.busy_o !== 1'b0)
      $display("FAIL midreset_no_accept: got ready=%b busy=%b want 0/0", bus.byte_ready_o, bus.busy_o);
    else pass_cnt++;
    total_cnt++;
    if (obs_wr.size() !== 0 || obs_start.size() !== 0)
      $display("FAIL midreset_quiet: got %0d writes %0d starts want 0/0", obs_wr.size(), obs_start.size());
    else pass_cnt++;
    bus.byte_valid_i = 1'b0;
    $display("test_reset_mid: done");
  endtask

  initial begin
    bus.load_i = 1'b0;
    bus.base_addr_i = 16'h0000;
    bus.byte_valid_i = 1'b0;
    bus.byte_i = 8'h00;
    test_reset();
    test_basic();
    test_empty();
    test_wrap();
    test_error();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; all state SHALL change only on the rising edge of clk.
REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- load_i  input  1  start a new program load; acted on in IDLE, DONE or ERR only
- base_addr_i  input  16  first instruction-memory address; also the start address handed to fetch
- byte_valid_i  input  1  byte_i carries a valid byte
- byte_i  input  8  host byte stream
- byte_ready_o  output  1  loader accepts byte_i this cycle
- imem_we_o  output  1  instruction-memory write strobe
- imem_addr_o  output  16  instruction-memory write address
- imem_data_o  output  9  instruction word: {format[1:0], opcode[3:0], reg[2:0]}
- start_o  output  1  one-cycle start pulse to fetch
- start_address_o  output  16  start address to fetch
- busy_o  output  1  load in progress
- done_o  output  1  last load completed
- err_o  output  1  last load aborted on a malformed byte

Function
REQ-003 A byte SHALL transfer only on a cycle where byte_valid_i and byte_ready_o are both 1.
REQ-004 The stream format SHALL be: LEN_LO, LEN_HI (16-bit instruction count N, little-endian), then N pairs INS_LO, INS_HI.
- instruction word = {INS_HI[0], INS_LO[7:0]}
- INS_HI[7:1] must be 0
REQ-005 The FSM SHALL have the states IDLE, LEN_LO, LEN_HI, INS_LO, INS_HI, WRITE, START, DONE and ERR.
REQ-006 byte_ready_o SHALL be 1 only in LEN_LO, LEN_HI, INS_LO and INS_HI.
REQ-007 The FSM SHALL make these transitions:
- IDLE/DONE/ERR + load_i -> LEN_LO: clear idx, done_o, err_o; latch base_addr_i
- LEN_LO + transfer -> LEN_HI
- LEN_HI + transfer -> START if N==0, else INS_LO
- INS_LO + transfer -> INS_HI
- INS_HI + transfer -> ERR if byte_i[7:1]!=0, else WRITE
- WRITE -> START if idx==N-1, else INS_LO; idx increments on every WRITE cycle
- START -> DONE
REQ-008 In WRITE, imem_we_o SHALL be 1 for exactly one cycle with imem_addr_o = (latched base + idx) mod 2^16; the address SHALL wrap from 0xFFFF to 0x0000 without error.
REQ-009 imem_we_o SHALL be 0 in all states other than WRITE; imem_addr_o and imem_data_o are don't-care when imem_we_o is 0.
REQ-010 In START, start_o SHALL be 1 for exactly one cycle, and start_address_o SHALL hold the latched base from that cycle until the next load_i is accepted.
REQ-011 busy_o SHALL be 1 in every state except IDLE, DONE and ERR.
REQ-012 done_o SHALL be 1 while in DONE; err_o SHALL be 1 while in ERR.
REQ-013 load_i SHALL be ignored while busy_o is 1.
REQ-014 A malformed byte SHALL abort the load with no write for that pair; words already written SHALL remain in memory, and start_o SHALL NOT pulse.
REQ-015 byte_valid_i low SHALL stall the FSM in its current state indefinitely, with no timeout.
REQ-016 N==0xFFFF SHALL be legal; idx SHALL be 16 bits wide.
REQ-017 Latency from the INS_HI transfer to imem_we_o SHALL be 1 cycle; from the last WRITE to start_o SHALL be 1 cycle.

Reset
REQ-018 On rising clk with rst_n==0, the FSM SHALL go to IDLE, and all outputs, idx, N and the latched base SHALL be 0.
REQ-019 Reset SHALL take priority over every other input, including mid-load; no write or start pulse SHALL occur in the reset cycle.
REQ-020 After reset, the FSM SHALL remain in IDLE until load_i is sampled 1 with rst_n==1.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- base=0x0010; load; bytes 02,00,A5,01,3C,00 with byte_valid_i always 1 -> writes (0x0010,0x1A5) and (0x0011,0x03C); start_o pulses once with start_address_o=0x0010; done_o=1.
- load with bytes 00,00 -> no imem_we_o; start_o pulses one cycle after the LEN_HI transfer; done_o=1.
- base=0xFFFF, N=2 -> writes at addresses 0xFFFF then 0x0000.
- N=2; second pair INS_HI=0x02 -> first word written, err_o=1, no start_o, busy_o=0; a subsequent load_i clears err_o.
- byte_valid_i toggled randomly -> byte_ready_o and imem writes match the stall-free run's write sequence exactly.
- rst_n=0 asserted during INS_LO -> next cycle all outputs 0, state IDLE; bytes presented afterwards are not accepted (byte_ready_o=0).
